sqrt_iter: RTL and testbench

SQRT_ITER -- requirements
Module: sqrt_iter

---
 rtl/sqrt_iter.sv | 94 +++++++++
 tb/tb_sqrt_iter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_iter.sv
// Iterative integer square root: one root bit per clock, MSB first, restoring shift/subtract.
// Define SQRT_REM_EN to add the registered remainder output r_bo.
module sqrt_iter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     x_bi,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WIDTH/2-1:0]   y_bo
`ifdef SQRT_REM_EN
  ,
  output logic [WIDTH/2:0]     r_bo
`endif
);

  localparam int RW  = WIDTH / 2;
  localparam int RMW = RW + 2;
  localparam int CW  = $clog2(RW + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, WORK} state_t;

  state_t           state;
  logic [WIDTH-1:0] xr;
  logic [RW-1:0]    q;
  logic [RMW-1:0]   rem;
  logic [CW-1:0]    cnt;

  logic [RMW-1:0]   rem_sh;
  logic [RMW-1:0]   trial;
  logic [RMW-1:0]   rem_nx;
  logic [RW-1:0]    q_nx;
  logic             fits;

  // The partial remainder never exceeds 2*q, so its top two bits are zero
  // whenever it is shifted; the cast drops them without losing information.
  always_comb begin
    rem_sh = RMW'({rem, xr[WIDTH-1 -: 2]});
    trial  = {q, 2'b01};
    fits   = (rem_sh >= trial);
    rem_nx = fits ? (rem_sh - trial) : rem_sh;
    q_nx   = {q[RW-2:0], fits};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      done_o <= 1'b0;
      y_bo   <= '0;
`ifdef SQRT_REM_EN
      r_bo   <= '0;
`endif
      cnt    <= '0;
      xr     <= '0;
      q      <= '0;
      rem    <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            xr    <= x_bi;
            q     <= '0;
            rem   <= '0;
            cnt   <= CNT_LOAD;
            state <= WORK;
          end
        end
        WORK: begin
          xr  <= xr << 2;
          q   <= q_nx;
          rem <= rem_nx;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state  <= IDLE;
            y_bo   <= q_nx;
`ifdef SQRT_REM_EN
            r_bo   <= rem_nx[RW:0];
`endif
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state == WORK);

endmodule

// File: tb/tb_sqrt_iter.sv
// Bench for sqrt_iter: WIDTH=16 directed vectors and WIDTH=8 exhaustive sweep,
// checked every cycle against a cycle-level behavioural model.
module tb_sqrt_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rs16 = 1'b1, st16 = 1'b0;
  logic [15:0] x16  = '0;
  logic        busy16, done16;
  logic [7:0]  y16;
  logic        rs8 = 1'b1, st8 = 1'b0;
  logic [7:0]  x8  = '0;
  logic        busy8, done8;
  logic [3:0]  y8;
`ifdef SQRT_REM_EN
  logic [8:0]  r16;
  logic [4:0]  r8;
`endif

  sqrt_iter #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rs16), .x_bi(x16), .start_i(st16),
    .busy_o(busy16), .done_o(done16), .y_bo(y16)
`ifdef SQRT_REM_EN
    , .r_bo(r16)
`endif
  );

  sqrt_iter #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rs8), .x_bi(x8), .start_i(st8),
    .busy_o(busy8), .done_o(done8), .y_bo(y8)
`ifdef SQRT_REM_EN
    , .r_bo(r8)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int isqrt(input int x);
    int y = 0;
    while ((y + 1) * (y + 1) <= x) y++;
    return y;
  endfunction

  // Model: an accepted request keeps the unit busy for RW cycles, then the
  // result appears with a one-cycle done.
  int m_left[2], m_x[2], m_y[2], m_r[2];
  bit m_done[2];
  int mw, mx;
  bit mrs, mst;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mw  = (d == 0) ? 8 : 4;
      mrs = (d == 0) ? rs16 : rs8;
      mst = (d == 0) ? st16 : st8;
      mx  = (d == 0) ? int'(x16) : int'(x8);
      if (mrs) begin
        m_left[d] = 0; m_done[d] = 0; m_y[d] = 0; m_r[d] = 0;
      end else begin
        m_done[d] = 0;
        if (m_left[d] != 0) begin
          m_left[d]--;
          if (m_left[d] == 0) begin
            m_y[d]    = isqrt(m_x[d]);
            m_r[d]    = m_x[d] - m_y[d] * m_y[d];
            m_done[d] = 1;
          end
        end else if (mst) begin
          m_x[d]    = mx;
          m_left[d] = mw;
        end
      end
    end
    #1;
    chk("busy16", busy16, m_left[0] != 0);
    chk("done16", done16, m_done[0]);
    chk("y16", y16, m_y[0]);
    chk("busy8", busy8, m_left[1] != 0);
    chk("done8", done8, m_done[1]);
    chk("y8", y8, m_y[1]);
`ifdef SQRT_REM_EN
    chk("r16", r16, m_r[0]);
    chk("r8", r8, m_r[1]);
`endif
  end

  task automatic go(input int d, input int x);
    @(negedge clk);
    if (d == 0) begin x16 = 16'(x); st16 = 1'b1; end
    else        begin x8  = 8'(x);  st8  = 1'b1; end
    @(negedge clk);
    st16 = 1'b0;
    st8  = 1'b0;
  endtask

  // Returns at the falling edge inside the done cycle; counts busy cycles seen.
  task automatic wait_done(input int d, output int bc);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if ((d == 0) ? done16 : done8) return;
      if ((d == 0) ? busy16 : busy8) bc++;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL wait_done%0d: no done within 40 cycles", d);
  endtask

  int bc;

  initial begin
    chk("pin_isqrt_0", isqrt(0), 0);
    chk("pin_isqrt_1000", isqrt(1000), 31);
    chk("pin_isqrt_65535", isqrt(65535), 255);
    chk("pin_isqrt_65025", isqrt(65025), 255);
    chk("pin_isqrt_255", isqrt(255), 15);

    repeat (3) @(negedge clk);
    rs16 = 1'b0;
    rs8  = 1'b0;
    chk("reset_y16", y16, 0);
    chk("reset_busy16", busy16, 0);

    go(0, 0);
    wait_done(0, bc);
    chk("x0_busy_len", bc, 8);
    chk("x0_y", y16, 0);

    go(0, 65535); wait_done(0, bc); chk("x65535_y", y16, 255);
`ifdef SQRT_REM_EN
    chk("x65535_r", r16, 510);
`endif
    go(0, 1000); wait_done(0, bc); chk("x1000_y", y16, 31);
`ifdef SQRT_REM_EN
    chk("x1000_r", r16, 39);
`endif
    go(0, 65025); wait_done(0, bc); chk("x65025_y", y16, 255);
`ifdef SQRT_REM_EN
    chk("x65025_r", r16, 0);
`endif

    // start held high and x changed throughout the busy window
    @(negedge clk);
    x16 = 16'd100; st16 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      x16 = 16'd9;
    end
    @(negedge clk);
    st16 = 1'b0;
    wait_done(0, bc);
    chk("hold_y", y16, 10);
    repeat (3) begin
      @(negedge clk);
      chk("hold_no_restart", busy16, 0);
    end

    // reset during the third busy cycle
    go(0, 50);
    @(negedge clk);
    @(negedge clk);
    rs16 = 1'b1;
    @(negedge clk);
    rs16 = 1'b0;
    chk("abort_busy", busy16, 0);
    chk("abort_y", y16, 0);
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_done", done16, 0);
    end
    go(0, 50); wait_done(0, bc); chk("x50_y", y16, 7);
`ifdef SQRT_REM_EN
    chk("x50_r", r16, 1);
`endif

    // back-to-back: new start in the done cycle
    go(0, 81);
    wait_done(0, bc);
    chk("b2b_first_y", y16, 9);
    x16 = 16'd2; st16 = 1'b1;
    @(negedge clk);
    st16 = 1'b0;
    chk("b2b_no_gap", busy16, 1);
    wait_done(0, bc);
    chk("b2b_busy_len", bc, 8);
    chk("b2b_second_y", y16, 1);
`ifdef SQRT_REM_EN
    chk("b2b_second_r", r16, 1);
`endif

    for (int x = 0; x < 256; x++) begin
      go(1, x);
      wait_done(1, bc);
      chk("w8_busy_len", bc, 4);
      chk("w8_y", y8, isqrt(x));
`ifdef SQRT_REM_EN
      chk("w8_r", r8, x - isqrt(x) * isqrt(x));
`endif
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
